// File: rtl/vec3_normalize_lut_if.sv
// Handshake bundle for the vector normaliser: input vector stream, inverse-sqrt LUT
// request/response port and normalised output stream.
interface vec3_normalize_lut_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_LENGTH = 12
);
   logic                           in_valid;
   logic                           in_ready;
   logic signed [DATA_WIDTH-1:0]   in_x;
   logic signed [DATA_WIDTH-1:0]   in_y;
   logic signed [DATA_WIDTH-1:0]   in_z;

   logic [ADDR_LENGTH-1:0]         lut_addr;
   logic                           lut_en;
   logic [DATA_WIDTH-1:0]          lut_data;
   logic                           lut_valid;

   logic                           out_valid;
   logic                           out_ready;
   logic signed [DATA_WIDTH-1:0]   out_x;
   logic signed [DATA_WIDTH-1:0]   out_y;
   logic signed [DATA_WIDTH-1:0]   out_z;
   logic                           out_zero;

   // The master drives vectors in, answers LUT reads and consumes results.
   modport master (
      output in_valid, in_x, in_y, in_z,
      input  in_ready,
      input  lut_addr, lut_en,
      output lut_data, lut_valid,
      input  out_valid, out_x, out_y, out_z, out_zero,
      output out_ready
   );

   modport slave (
      input  in_valid, in_x, in_y, in_z,
      output in_ready,
      output lut_addr, lut_en,
      input  lut_data, lut_valid,
      output out_valid, out_x, out_y, out_z, out_zero,
      input  out_ready
   );
endinterface

// File: rtl/vec3_normalize_lut.sv
// Normalises a signed fixed-point 3-vector using an external 1/sqrt LUT:
// square-and-sum, LUT lookup, then saturating scale of each component.
module vec3_normalize_lut #(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAC        = 16,
   parameter int ADDR_LENGTH = 12,
   parameter int ADDR_SHIFT  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vec3_normalize_lut_if.slave  bus_io
);

   localparam int SW = DATA_WIDTH + FRAC;
   localparam int PW = 2 * DATA_WIDTH;
   localparam int MW = 2 * DATA_WIDTH + 1;

   localparam logic signed [MW-1:0] MAX_V = {{(MW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [MW-1:0] MIN_V = {{(MW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ,
      S_SUM,
      S_REQ,
      S_WAIT,
      S_SCALE,
      S_OUT
   } state_t;

   state_t                         state_q, state_d;
   logic signed [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
   logic [SW-1:0]                  px_q, px_d, py_q, py_d, pz_q, pz_d;
   logic [ADDR_LENGTH-1:0]         lut_addr_q, lut_addr_d;
   logic [DATA_WIDTH-1:0]          lut_word_q, lut_word_d;
   logic signed [DATA_WIDTH-1:0]   out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
   logic                           out_zero_q, out_zero_d;

   logic [SW-1:0]                  sum;
   logic [SW-1:0]                  sum_shifted;
   logic [ADDR_LENGTH-1:0]         addr_clamped;

   // c*c is never negative, so the shifted square fits unsigned in SW bits.
   function automatic logic [SW-1:0] square_shift(input logic signed [DATA_WIDTH-1:0] c);
      logic signed [PW-1:0] ce;
      logic signed [PW-1:0] prod;
      ce   = PW'(c);
      prod = ce * ce;
      return SW'(prod >> FRAC);
   endfunction

   // LUT word is unsigned, so it is zero-extended before the signed multiply.
   function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic signed [DATA_WIDTH-1:0] c,
                                                       input logic [DATA_WIDTH-1:0] w);
      logic signed [MW-1:0] ce;
      logic signed [MW-1:0] we;
      logic signed [MW-1:0] prod;
      logic signed [MW-1:0] sh;
      ce   = MW'(c);
      we   = MW'({1'b0, w});
      prod = ce * we;
      sh   = prod >>> FRAC;
      if (sh > MAX_V) begin
         return MAX_V[DATA_WIDTH-1:0];
      end else if (sh < MIN_V) begin
         return MIN_V[DATA_WIDTH-1:0];
      end else begin
         return DATA_WIDTH'(sh);
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         px_q       <= '0;
         py_q       <= '0;
         pz_q       <= '0;
         lut_addr_q <= '0;
         lut_word_q <= '0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         out_z_q    <= '0;
         out_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         px_q       <= px_d;
         py_q       <= py_d;
         pz_q       <= pz_d;
         lut_addr_q <= lut_addr_d;
         lut_word_q <= lut_word_d;
         out_x_q    <= out_x_d;
         out_y_q    <= out_y_d;
         out_z_q    <= out_z_d;
         out_zero_q <= out_zero_d;
      end
   end

   // Any index beyond the table maps onto its last entry.
   always_comb begin
      sum          = px_q + py_q + pz_q;
      sum_shifted  = sum >> ADDR_SHIFT;
      addr_clamped = sum_shifted[ADDR_LENGTH-1:0];
      if (|(sum_shifted >> ADDR_LENGTH)) begin
         addr_clamped = '1;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      px_d       = px_q;
      py_d       = py_q;
      pz_d       = pz_q;
      lut_addr_d = lut_addr_q;
      lut_word_d = lut_word_q;
      out_x_d    = out_x_q;
      out_y_d    = out_y_q;
      out_z_d    = out_z_q;
      out_zero_d = out_zero_q;

      case (state_q)
         S_IDLE: begin
            if (bus_io.in_valid) begin
               x_d     = bus_io.in_x;
               y_d     = bus_io.in_y;
               z_d     = bus_io.in_z;
               state_d = S_SQ;
            end
         end
         S_SQ: begin
            px_d    = square_shift(x_q);
            py_d    = square_shift(y_q);
            pz_d    = square_shift(z_q);
            state_d = S_SUM;
         end
         S_SUM: begin
            if (sum == '0) begin
               out_x_d    = '0;
               out_y_d    = '0;
               out_z_d    = '0;
               out_zero_d = 1'b1;
               state_d    = S_OUT;
            end else begin
               lut_addr_d = addr_clamped;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         // Responses arriving in any other state are stale and dropped.
         S_WAIT: begin
            if (bus_io.lut_valid) begin
               lut_word_d = bus_io.lut_data;
               state_d    = S_SCALE;
            end
         end
         S_SCALE: begin
            out_x_d    = scale_sat(x_q, lut_word_q);
            out_y_d    = scale_sat(y_q, lut_word_q);
            out_z_d    = scale_sat(z_q, lut_word_q);
            out_zero_d = 1'b0;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (bus_io.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus_io.in_ready  = (state_q == S_IDLE);
   assign bus_io.lut_en    = (state_q == S_REQ);
   assign bus_io.lut_addr  = lut_addr_q;
   assign bus_io.out_valid = (state_q == S_OUT);
   assign bus_io.out_x     = out_x_q;
   assign bus_io.out_y     = out_y_q;
   assign bus_io.out_z     = out_z_q;
   assign bus_io.out_zero  = out_zero_q;

endmodule
